// File: rtl/delugish_exp_log.sv
`default_nettype none
// ============================================================================
// Module      : delugish_exp_log
// Description : Iterative De Lugish shift-and-add unit for the LNS MAC path.
//               mode 0 computes 2^x (x in Q0.WIDTH, result Q1.WIDTH in [1,2)).
//               mode 1 computes log2(x) (x in Q1.WIDTH in [1,2), result Q0.WIDTH).
//               One iteration per clock, ITER iterations plus one finalise
//               cycle, so a result is presented ITER+1 edges after acceptance.
// Ports       : clk, rstn          - clock, asynchronous active-low reset
//               mode_in, data_in   - operand and mode, sampled on acceptance
//               data_in_valid/_enable   - upstream handshake (enable in IDLE)
//               data_out, data_out_err, mode_out - result, range flag, mode
//               data_out_valid/_enable  - downstream handshake
// Options     : define DELUGISH_ROUND_EN for round-half-up of the final result
//               using the guard bits (requires GUARD >= 1); otherwise the
//               result is truncated.
// Revision    : 1.0 - initial release
// ============================================================================
module delugish_exp_log #(
    parameter int WIDTH = 8,
    parameter int ITER  = WIDTH,
    parameter int GUARD = 2
) (
    input  logic           clk,
    input  logic           rstn,
    input  logic           mode_in,
    input  logic [WIDTH:0] data_in,
    input  logic           data_in_valid,
    output logic           data_in_enable,
    output logic [WIDTH:0] data_out,
    output logic           data_out_valid,
    input  logic           data_out_enable,
    output logic           data_out_err,
    output logic           mode_out
);

    localparam int FRAC  = WIDTH + GUARD;      // internal fractional bits
    localparam int YW    = FRAC + 2;           // product/p register: 2 integer bits
    localparam int ZW    = FRAC + 1;           // angle register: 1 integer bit
    localparam int CNT_W = $clog2(ITER + 2);   // must hold ITER+1

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FIN = CNT_W'(ITER + 1);
    localparam logic [YW-1:0]    Y_ONE   = YW'(1) << FRAC;

    // floor(log2(1 + 2^-i) * 2^24), i = 1..16
    function automatic logic [23:0] l_rom(input logic [4:0] idx);
        logic [23:0] v;
        case (idx)
            5'd1:    v = 24'd9814042;
            5'd2:    v = 24'd5401057;
            5'd3:    v = 24'd2850868;
            5'd4:    v = 24'd1467382;
            5'd5:    v = 24'd744809;
            5'd6:    v = 24'd375269;
            5'd7:    v = 24'd188362;
            5'd8:    v = 24'd94364;
            5'd9:    v = 24'd47228;
            5'd10:   v = 24'd23625;
            5'd11:   v = 24'd11815;
            5'd12:   v = 24'd5908;
            5'd13:   v = 24'd2954;
            5'd14:   v = 24'd1477;
            5'd15:   v = 24'd738;
            5'd16:   v = 24'd369;
            default: v = 24'd0;
        endcase
        return v;
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             err_q, err_d;
    logic [WIDTH:0]   x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [ZW-1:0]    z_q, z_d;
    logic [WIDTH:0]   data_out_q, data_out_d;
    logic             data_out_err_q, data_out_err_d;
    logic             mode_out_q, mode_out_d;
    logic             data_in_enable_q, data_in_enable_d;

    logic [23:0]      l24;
    logic [ZW-1:0]    l_ext;
    logic [YW-1:0]    y_sum;
    logic [YW-1:0]    x_ext;
    logic [WIDTH:0]   exp_res;
    logic [WIDTH:0]   log_res;
    logic             unused_low_bits;

    assign l24   = l_rom(5'(cnt_q));
    assign l_ext = ZW'(l24[23 -: FRAC]);        // table truncated to FRAC bits
    assign y_sum = y_q + (y_q >> cnt_q);
    assign x_ext = YW'(x_q) << GUARD;
    assign unused_low_bits = ^{y_q, z_q};

`ifdef DELUGISH_ROUND_EN
    logic [WIDTH+2:0] exp_rnd;
    logic [WIDTH+1:0] log_rnd;

    assign exp_rnd = (WIDTH+3)'(y_q[YW-1:GUARD]) + (WIDTH+3)'(y_q[GUARD-1]);
    assign log_rnd = (WIDTH+2)'(z_q[ZW-1:GUARD]) + (WIDTH+2)'(z_q[GUARD-1]);
    // A carry into 2.0 (exp) or 1.0 (log) saturates to the largest code.
    assign exp_res = (exp_rnd[WIDTH+2:WIDTH+1] != 2'b00) ? {(WIDTH+1){1'b1}}
                                                         : exp_rnd[WIDTH:0];
    assign log_res = (log_rnd[WIDTH+1:WIDTH] != 2'b00) ? {1'b0, {WIDTH{1'b1}}}
                                                       : {1'b0, log_rnd[WIDTH-1:0]};
`else
    // Truncation; the saturation only guards against accumulated table error.
    assign exp_res = y_q[YW-1] ? {(WIDTH+1){1'b1}} : y_q[FRAC:GUARD];
    assign log_res = z_q[ZW-1] ? {1'b0, {WIDTH{1'b1}}} : {1'b0, z_q[FRAC-1:GUARD]};
`endif

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        mode_d         = mode_q;
        err_d          = err_q;
        x_d            = x_q;
        y_d            = y_q;
        z_d            = z_q;
        data_out_d     = data_out_q;
        data_out_err_d = data_out_err_q;
        mode_out_d     = mode_out_q;

        case (state_q)
            ST_IDLE: begin
                if (data_in_valid && data_in_enable_q) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_ONE;
                    mode_d  = mode_in;
                    x_d     = data_in;
                    // exp needs the integer bit clear, log needs it set
                    err_d   = mode_in ? ~data_in[WIDTH] : data_in[WIDTH];
                    y_d     = Y_ONE;
                    z_d     = mode_in ? '0 : (ZW'(data_in[WIDTH-1:0]) << GUARD);
                end
            end
            ST_BUSY: begin
                if (cnt_q == CNT_FIN) begin
                    state_d        = ST_DONE;
                    cnt_d          = '0;
                    mode_out_d     = mode_q;
                    data_out_err_d = err_q;
                    if (err_q) begin
                        data_out_d = '0;
                    end else begin
                        data_out_d = mode_q ? log_res : exp_res;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (!mode_q) begin
                        if (z_q >= l_ext) begin
                            z_d = z_q - l_ext;
                            y_d = y_sum;
                        end
                    end else begin
                        if (y_sum <= x_ext) begin
                            y_d = y_sum;
                            z_d = z_q + l_ext;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (data_out_enable) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        data_in_enable_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            mode_q           <= 1'b0;
            err_q            <= 1'b0;
            x_q              <= '0;
            y_q              <= '0;
            z_q              <= '0;
            data_out_q       <= '0;
            data_out_err_q   <= 1'b0;
            mode_out_q       <= 1'b0;
            data_in_enable_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            mode_q           <= mode_d;
            err_q            <= err_d;
            x_q              <= x_d;
            y_q              <= y_d;
            z_q              <= z_d;
            data_out_q       <= data_out_d;
            data_out_err_q   <= data_out_err_d;
            mode_out_q       <= mode_out_d;
            data_in_enable_q <= data_in_enable_d;
        end
    end

    assign data_in_enable = data_in_enable_q;
    assign data_out_valid = (state_q == ST_DONE);
    assign data_out       = data_out_q;
    assign data_out_err   = data_out_err_q;
    assign mode_out       = mode_out_q;

endmodule
`default_nettype wire
